// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS-subset main control FSM
// Optional: define ADDI_SUPPORT_EN to decode addi (opcode 001000).
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       mem_err,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic       waiting, timeout, legal;

  // Only the three memory-access states ever wait on mem_ready.
  assign waiting = ((cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR)) && !mem_ready;
  assign timeout = waiting && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef ADDI_SUPPORT_EN
      OP_ADDI: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = R_EXEC;
          OP_LW, OP_SW: nxt = MEM_ADR;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
`ifdef ADDI_SUPPORT_EN
          OP_ADDI:      nxt = ADDI_EXEC;
`endif
          default:      nxt = FETCH;
        endcase
      end
      MEM_ADR:   nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:    nxt = mem_ready ? MEM_WB : (timeout ? FETCH : MEM_RD);
      MEM_WR:    nxt = (mem_ready || timeout) ? FETCH : MEM_WR;
      R_EXEC:    nxt = R_WB;
`ifdef ADDI_SUPPORT_EN
      ADDI_EXEC: nxt = ADDI_WB;
`endif
      default:   nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= FETCH;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      cur      <= nxt;
      mem_err  <= timeout;
      wait_cnt <= (waiting && !timeout) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    illegal_op    = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        aluop     = 2'b11;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        aluop      = 2'b11;
        illegal_op = !legal;
      end
      MEM_ADR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = 2'b11;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC:  alu_src_a = 1'b1;
      R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized model-checked bench for mips_multicycle_control
module tb_mips_multicycle_control;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, mem_err, illegal_op;
  logic [1:0] pc_source, alu_src_b, aluop;
  logic [3:0] state;

  int vectors = 0, miscompares = 0;
  int ms = 0, mc = 0;
  bit m_err = 1'b0;
  int errs_seen = 0, ills_seen = 0;

  mips_multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .state(state),
    .mem_err(mem_err), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input int op);
`ifdef ADDI_SUPPORT_EN
    return op == 0 || op == 35 || op == 43 || op == 4 || op == 2 || op == 8;
`else
    return op == 0 || op == 35 || op == 43 || op == 4 || op == 2;
`endif
  endfunction

  // Cycles from FETCH back to FETCH with a zero-wait memory.
  function automatic int latency(input int op);
    case (op)
      35: return 5;
      0, 43: return 4;
      4, 2: return 3;
      default: return legal(op) ? 4 : 2;
    endcase
  endfunction

  function automatic logic [31:0] dut_vec();
    return {10'd0, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop,
            state, mem_err, illegal_op};
  endfunction

  function automatic logic [31:0] exp_vec(input int s, input int op, input bit rdy, input bit err);
    bit pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] ps = 0, asb = 0, aop = 0;
    case (s)
      0: begin mr = 1; asb = 1; aop = 3; irw = rdy; pw = rdy; end
      1: begin asb = 3; aop = 3; ill = !legal(op); end
      2, 10: begin asa = 1; asb = 2; aop = 3; end
      3: begin mr = 1; iod = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mw = 1; iod = 1; end
      6: asa = 1;
      7: begin rd = 1; rw = 1; end
      8: begin asa = 1; aop = 1; pwc = 1; ps = 1; end
      9: begin pw = 1; ps = 2; end
      11: rw = 1;
      default: ;
    endcase
    return {10'd0, pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop,
            4'(s), err, ill};
  endfunction

  task automatic model_step(input int op, input bit rdy);
    bit waiting, tmo;
    waiting = (ms == 0 || ms == 3 || ms == 5) && !rdy;
    tmo     = waiting && (mc == MEM_TIMEOUT - 1);
    m_err   = tmo;
    mc      = (waiting && !tmo) ? mc + 1 : 0;
    case (ms)
      0: ms = rdy ? 1 : 0;
      1: begin
        if (op == 0) ms = 6;
        else if (op == 35 || op == 43) ms = 2;
        else if (op == 4) ms = 8;
        else if (op == 2) ms = 9;
        else if (op == 8 && legal(op)) ms = 10;
        else ms = 0;
      end
      2: ms = (op == 43) ? 5 : 3;
      3: ms = rdy ? 4 : (tmo ? 0 : 3);
      5: ms = (rdy || tmo) ? 0 : 5;
      6: ms = 7;
      10: ms = 11;
      default: ms = 0;
    endcase
  endtask

  initial begin
    int ops[7] = '{0, 35, 43, 4, 2, 8, 63};
    int pct[3] = '{100, 60, 5};
    int cycles;

    @(negedge clk); #1;
    check("reset_state", dut_vec(), exp_vec(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    foreach (ops[i]) begin
      @(negedge clk);
      opcode = 6'(ops[i]);
      mem_ready = 1'b1;
      cycles = 0;
      do begin
        @(posedge clk); #1;
        cycles++;
      end while (state != 4'd0 && cycles < 20);
      check($sformatf("latency_op%0d", ops[i]), 32'(cycles), 32'(latency(ops[i])));
    end

    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        if (ms == 0) begin
          int k = $urandom_range(0, 7);
          opcode = (k == 7) ? 6'($urandom) : 6'(ops[k]);
        end
        mem_ready = ($urandom_range(0, 99) < pct[ph]);
        zero = 1'($urandom);
        #1;
        check($sformatf("ph%0d_s%0d", ph, ms), dut_vec(), exp_vec(ms, opcode, mem_ready, m_err));
        if (mem_err) errs_seen++;
        if (illegal_op) ills_seen++;
        model_step(opcode, mem_ready);
      end
    end
    check("mem_err_seen", 32'(errs_seen > 0), 32'd1);
    check("illegal_seen", 32'(ills_seen > 0), 32'd1);

    // Reset while a store waits in MEM_WR.
    @(negedge clk);
    opcode = 6'b101011;
    mem_ready = 1'b1;
    cycles = 0;
    while (state != 4'd5 && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    check("reach_mem_wr", 32'(state), 32'd5);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_mem_write", 32'(mem_write), 32'd0);
    check("rst_mid_mem_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
